// File: rtl/clock_division_pkg.sv
// Shared types and constants for the runtime-programmable clock divider.
package clock_division_pkg;

  localparam int DIV_WIDTH_DEFAULT = 8;
  localparam int ILLEGAL_RATIO     = 0;

  typedef enum logic [1:0] {
    STOPPED   = 2'd0,
    RUNNING   = 2'd1,
    SWITCHING = 2'd2
  } state_e;

endpackage

// File: rtl/division_counter.sv
// Half-period counter: counts 0..ratio-1, then reloads and toggles the divided phase.
module division_counter
  import clock_division_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic                 input_clock,
  input  logic                 reset,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic                 load_i,
  input  logic [DIV_WIDTH-1:0] ratio_i,
  output logic                 terminal_o,
  output logic                 phase_o
);

  logic [DIV_WIDTH-1:0] count_q;
  logic                 phase_q;

  assign terminal_o = enable_i && (count_q == ratio_i - DIV_WIDTH'(1));
  assign phase_o    = phase_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples the values from before the edge regardless of block order.
  always_ff @(posedge input_clock) begin
    if (!reset || clear_i) begin
      count_q <= '0;
      phase_q <= 1'b0;
    end else if (terminal_o) begin
      count_q <= '0;
      phase_q <= ~phase_q;
    end else if (load_i) begin
      count_q <= '0;
    end else if (enable_i) begin
      count_q <= count_q + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/clock_division_controller.sv
// Run/stop and ratio-switch controller; ratio changes land only on a falling edge
// of output_clock so the divided clock never shows a runt pulse.
module clock_division_controller
  import clock_division_pkg::*;
#(
  parameter int DIV_WIDTH        = DIV_WIDTH_DEFAULT,
  parameter int DEFAULT_DIVISION = 2
) (
  input  logic                 input_clock,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 cfg_valid,
  input  logic [DIV_WIDTH-1:0] cfg_division,
  output logic                 cfg_ready,
  output logic                 cfg_error,
  output logic                 output_clock,
  output logic                 clock_enable,
  output logic [DIV_WIDTH-1:0] division_active,
  output logic                 busy
);

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] division_q, division_d;
  logic [DIV_WIDTH-1:0] pending_q, pending_d;
  logic                 pending_valid_q, pending_valid_d;
  logic                 stop_pending_q, stop_pending_d;
  logic                 cfg_error_q, cfg_error_d;
  logic                 clock_enable_q, clock_enable_d;

  logic terminal, phase, load, clear;
  logic accept, accept_ok, fall_now;

  assign cfg_ready = (state_q != SWITCHING);
  assign busy      = (state_q == SWITCHING);
  assign accept    = cfg_valid && cfg_ready;
  assign accept_ok = accept && (cfg_division != DIV_WIDTH'(ILLEGAL_RATIO));
  assign fall_now  = terminal && phase;
  assign clear     = (state_d == STOPPED);

  division_counter #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_counter (
    .input_clock(input_clock),
    .reset      (reset),
    .enable_i   (state_q != STOPPED),
    .clear_i    (clear),
    .load_i     (load),
    .ratio_i    (division_q),
    .terminal_o (terminal),
    .phase_o    (phase)
  );

  // NOTE: every signal driven here gets a default first; otherwise a path that
  // leaves it unassigned would infer a latch.
  always_comb begin
    state_d         = state_q;
    division_d      = division_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    stop_pending_d  = stop_pending_q;
    cfg_error_d     = accept && (cfg_division == DIV_WIDTH'(ILLEGAL_RATIO));
    load            = 1'b0;

    unique case (state_q)
      STOPPED: begin
        if (accept_ok) begin
          division_d = cfg_division;
          load       = 1'b1;
        end
        if (run) state_d = RUNNING;
      end

      RUNNING: begin
        if (accept_ok && fall_now) begin
          // Already on a fall: the new ratio can take over on this very edge.
          division_d = cfg_division;
          load       = 1'b1;
          if (!run) state_d = STOPPED;
        end else if (accept_ok) begin
          pending_d       = cfg_division;
          pending_valid_d = 1'b1;
          stop_pending_d  = !run;
          state_d         = SWITCHING;
        end else if (!run) begin
          if (!phase || fall_now) begin
            state_d = STOPPED;
          end else begin
            stop_pending_d = 1'b1;
            state_d        = SWITCHING;
          end
        end
      end

      SWITCHING: begin
        stop_pending_d = !run;
        if (fall_now) begin
          if (pending_valid_q) begin
            division_d = pending_q;
            load       = 1'b1;
          end
          pending_valid_d = 1'b0;
          stop_pending_d  = 1'b0;
          state_d         = (stop_pending_q || !run) ? STOPPED : RUNNING;
        end
      end

      default: state_d = STOPPED;
    endcase

    clock_enable_d = terminal && !phase && !clear;
  end

  always_ff @(posedge input_clock) begin
    if (!reset) begin
      state_q         <= STOPPED;
      division_q      <= DIV_WIDTH'(DEFAULT_DIVISION);
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      stop_pending_q  <= 1'b0;
      cfg_error_q     <= 1'b0;
      clock_enable_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      division_q      <= division_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      stop_pending_q  <= stop_pending_d;
      cfg_error_q     <= cfg_error_d;
      clock_enable_q  <= clock_enable_d;
    end
  end

  assign cfg_error       = cfg_error_q;
  assign clock_enable    = clock_enable_q;
  assign output_clock    = phase;
  assign division_active = division_q;

endmodule

// File: tb/tb_clock_division_controller.sv
// Directed self-checking bench for clock_division_controller.
module tb_clock_division_controller;

  logic       input_clock = 1'b0;
  logic       reset;
  logic       run;
  logic       cfg_valid;
  logic [7:0] cfg_division;
  logic       cfg_ready;
  logic       cfg_error;
  logic       output_clock;
  logic       clock_enable;
  logic [7:0] division_active;
  logic       busy;

  int checks = 0;
  int fails  = 0;

  clock_division_controller #(
    .DIV_WIDTH       (8),
    .DEFAULT_DIVISION(2)
  ) dut (
    .input_clock    (input_clock),
    .reset          (reset),
    .run            (run),
    .cfg_valid      (cfg_valid),
    .cfg_division   (cfg_division),
    .cfg_ready      (cfg_ready),
    .cfg_error      (cfg_error),
    .output_clock   (output_clock),
    .clock_enable   (clock_enable),
    .division_active(division_active),
    .busy           (busy)
  );

  always #5 input_clock = ~input_clock;

  task automatic tick;
    @(posedge input_clock);
    #1;
  endtask

  task automatic do_reset;
    reset        = 1'b0;
    run          = 1'b0;
    cfg_valid    = 1'b0;
    cfg_division = 8'd0;
    tick;
    tick;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    reset = 1'b0;
    tick;
    checks++; if (output_clock !== 1'b0) begin fails++; $display("FAIL reset_oc: got %b want 0", output_clock); end
    checks++; if (clock_enable !== 1'b0) begin fails++; $display("FAIL reset_ce: got %b want 0", clock_enable); end
    checks++; if (cfg_error !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", cfg_error); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
    checks++; if (division_active !== 8'd2) begin fails++; $display("FAIL reset_div: got %0d want 2", division_active); end
    reset = 1'b1;
  endtask

  // D=2: rise at edge 3, period 4, one enable per rise.
  task automatic test_basic;
    logic [11:0] exp_oc, exp_ce;
    exp_oc = 12'b1100_1100_1100;
    exp_ce = 12'b0100_0100_0100;
    do_reset;
    run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick;
      checks++; if (output_clock !== exp_oc[i]) begin fails++; $display("FAIL basic_oc edge %0d: got %b want %b", i + 1, output_clock, exp_oc[i]); end
      checks++; if (clock_enable !== exp_ce[i]) begin fails++; $display("FAIL basic_ce edge %0d: got %b want %b", i + 1, clock_enable, exp_ce[i]); end
    end
  endtask

  // D=3, accept 5 mid-high: old high stays 3, then 5 low / 5 high.
  task automatic test_switch;
    logic [4:0] exp_start;
    logic [9:0] exp_oc, exp_ce;
    exp_start = 5'b11000;
    exp_oc    = 10'b01_1111_0000;
    exp_ce    = 10'b00_0001_0000;
    do_reset;
    cfg_valid = 1'b1; cfg_division = 8'd3;
    tick;
    cfg_valid = 1'b0;
    checks++; if (division_active !== 8'd3) begin fails++; $display("FAIL switch_load3: got %0d want 3", division_active); end
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++; if (output_clock !== exp_start[i]) begin fails++; $display("FAIL switch_pre_oc edge %0d: got %b want %b", i + 1, output_clock, exp_start[i]); end
    end
    checks++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL switch_ready_before: got %b want 1", cfg_ready); end
    cfg_valid = 1'b1; cfg_division = 8'd5;
    tick;
    cfg_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL switch_busy: got %b want 1", busy); end
    checks++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL switch_ready: got %b want 0", cfg_ready); end
    checks++; if (output_clock !== 1'b1) begin fails++; $display("FAIL switch_old_high: got %b want 1", output_clock); end
    checks++; if (division_active !== 8'd3) begin fails++; $display("FAIL switch_div_old: got %0d want 3", division_active); end
    tick;
    checks++; if (output_clock !== 1'b0) begin fails++; $display("FAIL switch_fall: got %b want 0", output_clock); end
    checks++; if (division_active !== 8'd5) begin fails++; $display("FAIL switch_div_new: got %0d want 5", division_active); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL switch_busy_clear: got %b want 0", busy); end
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++; if (output_clock !== exp_oc[i]) begin fails++; $display("FAIL switch_new_oc edge %0d: got %b want %b", i + 8, output_clock, exp_oc[i]); end
      checks++; if (clock_enable !== exp_ce[i]) begin fails++; $display("FAIL switch_new_ce edge %0d: got %b want %b", i + 8, clock_enable, exp_ce[i]); end
    end
  endtask

  // Ratio 0 is rejected with a one-cycle error; phase is untouched.
  task automatic test_error;
    do_reset;
    run = 1'b1;
    repeat (4) tick;
    cfg_valid = 1'b1; cfg_division = 8'd0;
    tick;
    cfg_valid = 1'b0;
    checks++; if (cfg_error !== 1'b1) begin fails++; $display("FAIL error_pulse: got %b want 1", cfg_error); end
    checks++; if (division_active !== 8'd2) begin fails++; $display("FAIL error_div: got %0d want 2", division_active); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL error_busy: got %b want 0", busy); end
    checks++; if (output_clock !== 1'b0) begin fails++; $display("FAIL error_oc5: got %b want 0", output_clock); end
    tick;
    checks++; if (cfg_error !== 1'b0) begin fails++; $display("FAIL error_one_cycle: got %b want 0", cfg_error); end
    checks++; if (output_clock !== 1'b0) begin fails++; $display("FAIL error_oc6: got %b want 0", output_clock); end
    tick;
    checks++; if (output_clock !== 1'b1) begin fails++; $display("FAIL error_oc7: got %b want 1", output_clock); end
    checks++; if (clock_enable !== 1'b1) begin fails++; $display("FAIL error_ce7: got %b want 1", clock_enable); end
  endtask

  // D=4, run dropped during high: high completes 4 cycles, then stopped.
  task automatic test_stop_high;
    logic [8:0] exp_oc, exp_busy;
    exp_oc   = 9'b0_1111_0000;
    exp_busy = 9'b0_1100_0000;
    do_reset;
    cfg_valid = 1'b1; cfg_division = 8'd4;
    tick;
    cfg_valid = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick;
      if (i == 5) run = 1'b0;
      checks++; if (output_clock !== exp_oc[i]) begin fails++; $display("FAIL stop_oc edge %0d: got %b want %b", i + 1, output_clock, exp_oc[i]); end
      checks++; if (busy !== exp_busy[i]) begin fails++; $display("FAIL stop_busy edge %0d: got %b want %b", i + 1, busy, exp_busy[i]); end
    end
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++; if (output_clock !== 1'b0 || clock_enable !== 1'b0) begin fails++; $display("FAIL stop_idle edge %0d: got oc=%b ce=%b want 0 0", i + 10, output_clock, clock_enable); end
    end
    checks++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL stop_ready: got %b want 1", cfg_ready); end
  endtask

  // Accept D=1 and drop run together: ratio lands at the fall, then stopped.
  task automatic test_back_to_back;
    do_reset;
    run = 1'b1;
    repeat (3) tick;
    cfg_valid = 1'b1; cfg_division = 8'd1; run = 1'b0;
    tick;
    cfg_valid = 1'b0;
    checks++; if (busy !== 1'b1 || output_clock !== 1'b1) begin fails++; $display("FAIL b2b_pending: got busy=%b oc=%b want 1 1", busy, output_clock); end
    checks++; if (division_active !== 8'd2) begin fails++; $display("FAIL b2b_div_old: got %0d want 2", division_active); end
    tick;
    checks++; if (output_clock !== 1'b0) begin fails++; $display("FAIL b2b_fall: got %b want 0", output_clock); end
    checks++; if (division_active !== 8'd1) begin fails++; $display("FAIL b2b_div_new: got %0d want 1", division_active); end
    checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin fails++; $display("FAIL b2b_stopped: got busy=%b ready=%b want 0 1", busy, cfg_ready); end
    repeat (3) tick;
    checks++; if (output_clock !== 1'b0) begin fails++; $display("FAIL b2b_idle: got %b want 0", output_clock); end
    run = 1'b1;
    tick;
    checks++; if (output_clock !== 1'b0) begin fails++; $display("FAIL b2b_start: got %b want 0", output_clock); end
    for (int i = 0; i < 6; i++) begin
      tick;
      checks++; if (output_clock !== ((i % 2) == 0)) begin fails++; $display("FAIL b2b_toggle_oc %0d: got %b want %b", i, output_clock, (i % 2) == 0); end
      checks++; if (clock_enable !== ((i % 2) == 0)) begin fails++; $display("FAIL b2b_toggle_ce %0d: got %b want %b", i, clock_enable, (i % 2) == 0); end
    end
  endtask

  // Reset during SWITCHING discards the pending ratio.
  task automatic test_reset_switching;
    logic [3:0] exp_oc;
    exp_oc = 4'b1100;
    do_reset;
    run = 1'b1;
    repeat (3) tick;
    cfg_valid = 1'b1; cfg_division = 8'd7;
    tick;
    cfg_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL rsw_busy: got %b want 1", busy); end
    reset = 1'b0;
    tick;
    checks++; if (output_clock !== 1'b0 || clock_enable !== 1'b0 || cfg_error !== 1'b0) begin fails++; $display("FAIL rsw_outs: got oc=%b ce=%b err=%b want 0 0 0", output_clock, clock_enable, cfg_error); end
    checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin fails++; $display("FAIL rsw_hs: got busy=%b ready=%b want 0 1", busy, cfg_ready); end
    checks++; if (division_active !== 8'd2) begin fails++; $display("FAIL rsw_div: got %0d want 2", division_active); end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++; if (output_clock !== exp_oc[i]) begin fails++; $display("FAIL rsw_oc edge %0d: got %b want %b", i + 6, output_clock, exp_oc[i]); end
    end
    checks++; if (division_active !== 8'd2) begin fails++; $display("FAIL rsw_div_after: got %0d want 2", division_active); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_switch;
    test_error;
    test_stop_high;
    test_back_to_back;
    test_reset_switching;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/clock_division_controller.md
# clock_division_controller

Runtime-programmable clock divider with a configuration handshake, glitch-free ratio switching and a run/stop control. It produces a divided clock and a matching one-cycle enable strobe for downstream image-processing stages. It lets software change the division ratio (1..255) without rebuilding the bitstream and without runt pulses on the divided clock.

## Interface
Parameters:
- DIV_WIDTH, 8, width of the division ratio.
- DEFAULT_DIVISION, 2, ratio loaded at reset; must be in 1..2^DIV_WIDTH-1.

Ports:
- input_clock  in  1  source clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low.
- run  in  1  level; 1 = divider runs, 0 = stop at next safe point.
- cfg_valid  in  1  new ratio offered.
- cfg_division  in  DIV_WIDTH  requested half-period in input_clock cycles.
- cfg_ready  out  1  controller can accept a ratio this cycle.
- cfg_error  out  1  one-cycle pulse: accepted request had ratio 0.
- output_clock  out  1  divided clock, registered.
- clock_enable  out  1  one-cycle pulse on the cycle output_clock goes 0→1.
- division_active  out  DIV_WIDTH  ratio currently in effect.
- busy  out  1  1 while a ratio switch or stop is pending.

## Operation
- Handshake: a transfer occurs on a cycle with cfg_valid && cfg_ready. cfg_division is sampled on that cycle only.
- Ratio 0 is rejected. cfg_error = 1 on the next cycle; state and division_active are unchanged.
- Half-period = division_active cycles. Period = 2 × division_active. Ratio 1 gives output_clock toggling every cycle.
- Counter runs 0..D-1. At D-1: output_clock toggles and the counter reloads 0.
- FSM states:
  - STOPPED:
    - output_clock = 0, counter = 0, cfg_ready = 1.
    - An accepted ratio loads division_active on the next cycle.
    - run = 1 → RUNNING next cycle, with counter = 0.
  - RUNNING:
    - cfg_ready = 1.
    - An accepted nonzero ratio is stored as pending → SWITCHING.
    - run = 0 with output_clock = 0 → STOPPED next cycle.
    - run = 0 with output_clock = 1 → SWITCHING with stop_pending set.
  - SWITCHING:
    - cfg_ready = 0, busy = 1. The old ratio continues.
    - On the cycle output_clock falls (1→0): the pending ratio, if any, loads into division_active and the counter reloads 0.
    - Then → STOPPED if stop_pending or run = 0, else → RUNNING.
    - If entered with output_clock = 0, the switch waits for the next fall. The low phase is never truncated by a switch.
- run = 0 arriving while in SWITCHING sets stop_pending. run = 1 returning before the fall clears it.
- Accept and run falling in the same RUNNING cycle: both take effect. The ratio is applied at the fall, then → STOPPED.
- A stop never shortens a high phase. It may shorten a low phase, which is allowed: no runt high pulse.

## Timing
- Reset values:
  - output_clock = 0, clock_enable = 0, cfg_error = 0, busy = 0.
  - cfg_ready = 1, division_active = DEFAULT_DIVISION.
  - State STOPPED. Pending ratio and stop_pending are cleared.
- Reset applies mid-operation on the next edge and discards any pending switch.
- run rising in STOPPED:
  - RUNNING is entered on edge +1.
  - output_clock first rises on edge +1+D.
  - clock_enable is high for that same cycle.
- Ratio switch latency: 0..2D-1 cycles after the accept, depending on phase. The new ratio's first high phase starts exactly D_new cycles after the fall.
- division_active updates on the same edge as the falling output_clock.
- busy deasserts on the cycle after that edge.
- cfg_ready is combinational from state only, with no dependency on cfg_valid.

## Structure
- Package clock_division_pkg holds:
  - the state encoding (STOPPED, RUNNING, SWITCHING);
  - DIV_WIDTH default;
  - the illegal-ratio constant 0.
- One sub-module: division_counter.
  - Inputs: load, ratio.
  - Outputs: terminal-count pulse and toggled phase.
  - The FSM stays in clock_division_controller.

## Test plan
- Reset, run = 1, D = 2 → output_clock rises at edge 3; period 4; clock_enable high one cycle per rising edge.
- Running at D = 3, accept 5 mid-high-phase → busy = 1, cfg_ready = 0; old highs stay 3 cycles; after the fall, lows and highs are 5 cycles; division_active reads 5 from the fall edge.
- Accept cfg_division = 0 → cfg_error pulses 1 cycle; division_active and output_clock phase unchanged.
- run = 0 while output_clock high at D = 4 → high completes its 4 cycles, then STOPPED with output_clock = 0; no further clock_enable.
- Accept D = 1 and drop run in the same cycle → ratio applied at the fall, state STOPPED; a later run = 1 gives a toggle every cycle.
- Reset asserted during SWITCHING → next cycle: outputs at reset values, division_active = 2, pending ratio discarded.
